// File: rtl/conv_stream_ctrl.sv
// Sequencing controller for the UART-fed streaming convolution path:
// pixel write strobes, window scheduling, result FIFO and TX handshake.
module conv_stream_ctrl #(
  parameter int unsigned row_depth    = 9,
  parameter int unsigned column_depth = 9,
  parameter int unsigned K            = 7,
  parameter int unsigned D_BITS       = 8,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                                     i_clk,
  input  logic                                     reset,
  input  logic [D_BITS-1:0]                        i_data,
  input  logic                                     i_drdy,
  output logic                                     o_wr_mem,
  output logic [$clog2(row_depth*column_depth)-1:0] o_wr_addr,
  output logic [D_BITS-1:0]                        o_wr_data,
  output logic                                     o_conv_start,
  output logic [$clog2(row_depth)-1:0]             o_win_row,
  output logic [$clog2(column_depth)-1:0]          o_win_col,
  input  logic                                     i_conv_done,
  input  logic [D_BITS-1:0]                        i_conv_data,
  output logic [D_BITS-1:0]                        o_tx_data,
  output logic                                     o_tx_enable,
  input  logic                                     i_tx_rdy,
  output logic                                     o_busy,
  output logic                                     o_frame_done
);

  localparam int unsigned NPIX = row_depth * column_depth;
  localparam int unsigned AW   = $clog2(NPIX);
  localparam int unsigned RW   = $clog2(row_depth);
  localparam int unsigned CW   = $clog2(column_depth);
  localparam int unsigned NJOB = (row_depth - K + 1) * (column_depth - K + 1);
  localparam int unsigned PW   = $clog2(NJOB + 1);
  localparam int unsigned FPW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCW  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {C_IDLE, C_WAIT} conv_state_e;
  typedef enum logic [1:0] {T_IDLE, T_BUSY, T_DRAIN} tx_state_e;

  conv_state_e conv_state_q, conv_state_d;
  tx_state_e   tx_state_q, tx_state_d;

  logic [RW-1:0]     pix_row_q, pix_row_d, job_row_q, job_row_d, win_row_q, win_row_d;
  logic [CW-1:0]     pix_col_q, pix_col_d, job_col_q, job_col_d, win_col_q, win_col_d;
  logic [AW-1:0]     pix_idx_q, pix_idx_d, wr_addr_q, wr_addr_d;
  logic [D_BITS-1:0] wr_data_q, wr_data_d, tx_data_q, tx_data_d;
  logic              wr_mem_q, wr_mem_d, conv_start_q, conv_start_d;
  logic              tx_enable_q, tx_enable_d, busy_q, busy_d, frame_done_q, frame_done_d;
  logic [PW-1:0]     pending_q, pending_d, sent_q, sent_d;
  logic [FPW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0]    fifo_cnt_q, fifo_cnt_d;
  logic [D_BITS-1:0] fifo_q [FIFO_DEPTH];
  logic [D_BITS-1:0] fifo_d [FIFO_DEPTH];
  logic              pix_enq, conv_push, tx_pop;

  always_comb begin
    pix_row_d    = pix_row_q;
    pix_col_d    = pix_col_q;
    pix_idx_d    = pix_idx_q;
    wr_mem_d     = i_drdy;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    pix_enq      = 1'b0;
    conv_state_d = conv_state_q;
    conv_start_d = 1'b0;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    job_row_d    = job_row_q;
    job_col_d    = job_col_q;
    conv_push    = 1'b0;
    tx_state_d   = tx_state_q;
    tx_enable_d  = 1'b0;
    tx_data_d    = tx_data_q;
    tx_pop       = 1'b0;
    sent_d       = sent_q;
    frame_done_d = 1'b0;
    pending_d    = pending_q;
    fifo_d       = fifo_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_cnt_d   = fifo_cnt_q;

    // Raster ingest; a pixel completing a window's bottom-right corner queues a job
    if (i_drdy) begin
      wr_addr_d = pix_idx_q;
      wr_data_d = i_data;
      pix_enq   = (pix_row_q >= RW'(K - 1)) && (pix_col_q >= CW'(K - 1));
      pix_idx_d = (pix_idx_q == AW'(NPIX - 1)) ? '0 : pix_idx_q + AW'(1);
      if (pix_col_q == CW'(column_depth - 1)) begin
        pix_col_d = '0;
        pix_row_d = (pix_row_q == RW'(row_depth - 1)) ? '0 : pix_row_q + RW'(1);
      end else begin
        pix_col_d = pix_col_q + CW'(1);
      end
    end

    unique case (conv_state_q)
      C_IDLE: begin
        if ((pending_q != '0) && (fifo_cnt_q < FCW'(FIFO_DEPTH))) begin
          conv_state_d = C_WAIT;
          conv_start_d = 1'b1;
          win_row_d    = job_row_q;
          win_col_d    = job_col_q;
        end
      end
      C_WAIT: begin
        if (i_conv_done) begin
          conv_state_d = C_IDLE;
          conv_push    = 1'b1;
          if (job_col_q == CW'(column_depth - K)) begin
            job_col_d = '0;
            job_row_d = (job_row_q == RW'(row_depth - K)) ? '0 : job_row_q + RW'(1);
          end else begin
            job_col_d = job_col_q + CW'(1);
          end
        end
      end
      default: conv_state_d = C_IDLE;
    endcase

    unique case (tx_state_q)
      T_IDLE: begin
        if ((fifo_cnt_q != '0) && i_tx_rdy) begin
          tx_state_d  = T_BUSY;
          tx_pop      = 1'b1;
          tx_enable_d = 1'b1;
          tx_data_d   = fifo_q[rd_ptr_q];
        end
      end
      T_BUSY:  if (!i_tx_rdy) tx_state_d = T_DRAIN;
      T_DRAIN: begin
        if (i_tx_rdy) begin
          tx_state_d = T_IDLE;
          if (sent_q == PW'(NJOB - 1)) begin
            sent_d       = '0;
            frame_done_d = 1'b1;
          end else begin
            sent_d = sent_q + PW'(1);
          end
        end
      end
      default: tx_state_d = T_IDLE;
    endcase

    // Simultaneous enqueue and completion leave the pending count unchanged
    unique case ({pix_enq, conv_push})
      2'b10:   pending_d = pending_q + PW'(1);
      2'b01:   pending_d = pending_q - PW'(1);
      default: pending_d = pending_q;
    endcase

    if (conv_push) begin
      fifo_d[wr_ptr_q] = i_conv_data;
      wr_ptr_d = (wr_ptr_q == FPW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + FPW'(1);
    end
    if (tx_pop) begin
      rd_ptr_d = (rd_ptr_q == FPW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + FPW'(1);
    end
    unique case ({conv_push, tx_pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + FCW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - FCW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    busy_d = (pending_d != '0) || (conv_state_d == C_WAIT) ||
             (fifo_cnt_d != '0) || (tx_state_d != T_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      conv_state_q <= C_IDLE;
      tx_state_q   <= T_IDLE;
      pix_row_q    <= '0;
      pix_col_q    <= '0;
      pix_idx_q    <= '0;
      job_row_q    <= '0;
      job_col_q    <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      wr_mem_q     <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      conv_start_q <= 1'b0;
      tx_enable_q  <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      pending_q    <= '0;
      sent_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      fifo_q       <= '{default: '0};
    end else begin
      conv_state_q <= conv_state_d;
      tx_state_q   <= tx_state_d;
      pix_row_q    <= pix_row_d;
      pix_col_q    <= pix_col_d;
      pix_idx_q    <= pix_idx_d;
      job_row_q    <= job_row_d;
      job_col_q    <= job_col_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      wr_mem_q     <= wr_mem_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      conv_start_q <= conv_start_d;
      tx_enable_q  <= tx_enable_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      pending_q    <= pending_d;
      sent_q       <= sent_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      fifo_q       <= fifo_d;
    end
  end

  assign o_wr_mem     = wr_mem_q;
  assign o_wr_addr    = wr_addr_q;
  assign o_wr_data    = wr_data_q;
  assign o_conv_start = conv_start_q;
  assign o_win_row    = win_row_q;
  assign o_win_col    = win_col_q;
  assign o_tx_data    = tx_data_q;
  assign o_tx_enable  = tx_enable_q;
  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Directed bench for conv_stream_ctrl: 9x9 image, K=7, with a 3-cycle
// convolution responder and a transmitter that stays busy 20 cycles per byte.
`timescale 1ns/1ps
module tb_conv_stream_ctrl;

  logic       i_clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] i_data = 8'h00;
  logic       i_drdy = 1'b0;
  logic       o_wr_mem;
  logic [6:0] o_wr_addr;
  logic [7:0] o_wr_data;
  logic       o_conv_start;
  logic [3:0] o_win_row;
  logic [3:0] o_win_col;
  logic       i_conv_done = 1'b0;
  logic [7:0] i_conv_data = 8'h00;
  logic [7:0] o_tx_data;
  logic       o_tx_enable;
  logic       i_tx_rdy = 1'b1;
  logic       o_busy;
  logic       o_frame_done;

  conv_stream_ctrl dut (
    .i_clk(i_clk), .reset(reset), .i_data(i_data), .i_drdy(i_drdy),
    .o_wr_mem(o_wr_mem), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_conv_start(o_conv_start), .o_win_row(o_win_row), .o_win_col(o_win_col),
    .i_conv_done(i_conv_done), .i_conv_data(i_conv_data),
    .o_tx_data(o_tx_data), .o_tx_enable(o_tx_enable), .i_tx_rdy(i_tx_rdy),
    .o_busy(o_busy), .o_frame_done(o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Window anchors and the results the responder returns for them, in issue order
  int unsigned exp_row  [9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
  int unsigned exp_col  [9] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
  int unsigned exp_byte [9] = '{8'h30, 8'h31, 8'h32, 8'h40, 8'h41, 8'h42, 8'h50, 8'h51, 8'h52};

  logic tx_hold = 1'b0;
  logic spur    = 1'b0;
  logic clr     = 1'b0;

  int       conv_timer = 0;
  logic [7:0] conv_res = 8'h00;
  int       tx_timer = 0;

  always @(posedge i_clk) begin
    #1;
    i_conv_done = 1'b0;
    if (reset) begin
      conv_timer = 0;
    end else if (spur) begin
      i_conv_done = 1'b1;
      i_conv_data = 8'hEE;
    end else if (o_conv_start) begin
      conv_timer = 3;
      conv_res   = 8'h30 + {o_win_row, 4'h0} + {4'h0, o_win_col};
    end else if (conv_timer > 0) begin
      conv_timer--;
      if (conv_timer == 0) begin
        i_conv_done = 1'b1;
        i_conv_data = conv_res;
      end
    end
  end

  always @(posedge i_clk) begin
    #1;
    if (reset) tx_timer = 0;
    else if (o_tx_enable) tx_timer = 21;
    else if (tx_timer > 0) tx_timer--;
    i_tx_rdy = !tx_hold && (tx_timer == 0 || tx_timer == 21);
  end

  int         cyc = 0;
  int         w60_cyc = -1;
  int         st1_cyc = -1;
  int         frame_cnt = 0;
  logic [6:0] wr_addrs[$];
  logic [7:0] wr_datas[$];
  logic [3:0] st_rows[$];
  logic [3:0] st_cols[$];
  logic [7:0] tx_bytes[$];

  always @(posedge i_clk) begin
    #1;
    cyc++;
    if (clr) begin
      wr_addrs.delete(); wr_datas.delete();
      st_rows.delete(); st_cols.delete(); tx_bytes.delete();
      w60_cyc = -1; st1_cyc = -1; frame_cnt = 0;
    end else begin
      if (o_wr_mem) begin
        wr_addrs.push_back(o_wr_addr);
        wr_datas.push_back(o_wr_data);
        if (o_wr_addr == 7'd60 && w60_cyc < 0) w60_cyc = cyc;
      end
      if (o_conv_start) begin
        st_rows.push_back(o_win_row);
        st_cols.push_back(o_win_col);
        if (st1_cyc < 0) st1_cyc = cyc;
      end
      if (o_tx_enable) tx_bytes.push_back(o_tx_data);
      if (o_frame_done) frame_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix_data(input int p);
    return 8'((p * 7 + 3) % 256);
  endfunction

  task automatic send_pixel(input int p);
    i_drdy = 1'b1;
    i_data = pix_data(p);
    @(negedge i_clk);
    i_drdy = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    reset = 1'b1; clr = 1'b1; i_drdy = 1'b0;
    repeat (3) @(negedge i_clk);
    reset = 1'b0; clr = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_a"}, {o_wr_mem, o_wr_addr, o_wr_data, o_conv_start, o_win_row, o_win_col}, 32'h0);
    chk({tag, "_b"}, {o_tx_data, o_tx_enable, o_busy, o_frame_done}, 32'h0);
  endtask

  task automatic wait_frames(input int nf, input int budget);
    int n = 0;
    while (frame_cnt < nf && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    chk("frame_wait_in_budget", 32'(frame_cnt >= nf), 32'h1);
    repeat (30) @(negedge i_clk);
  endtask

  task automatic check_writes(input int n);
    chk("write_count", wr_addrs.size(), n);
    for (int i = 0; i < n && i < wr_addrs.size(); i++) begin
      chk($sformatf("wr_addr[%0d]", i), wr_addrs[i], i % 81);
      chk($sformatf("wr_data[%0d]", i), wr_datas[i], pix_data(i));
    end
  endtask

  task automatic check_results(input int nf);
    chk("start_count", st_rows.size(), 9 * nf);
    for (int i = 0; i < 9 * nf && i < st_rows.size(); i++) begin
      chk($sformatf("win_row[%0d]", i), st_rows[i], exp_row[i % 9]);
      chk($sformatf("win_col[%0d]", i), st_cols[i], exp_col[i % 9]);
    end
    chk("tx_count", tx_bytes.size(), 9 * nf);
    for (int i = 0; i < 9 * nf && i < tx_bytes.size(); i++)
      chk($sformatf("tx_byte[%0d]", i), tx_bytes[i], exp_byte[i % 9]);
    chk("frame_done_count", frame_cnt, nf);
    chk("busy_after_frame", o_busy, 1'b0);
  endtask

  initial begin
    int t60;
    int n_st;
    int n_tx;

    // Reset state, then a stray completion while no window is outstanding
    do_reset();
    chk_idle_outputs("reset_state");
    @(negedge i_clk);
    spur = 1'b1;
    @(negedge i_clk);
    spur = 1'b0;
    repeat (30) @(negedge i_clk);
    chk("spurious_tx_count", tx_bytes.size(), 0);
    chk("spurious_starts", st_rows.size(), 0);
    chk("spurious_busy", o_busy, 1'b0);

    // Full frame with normal conv and TX behaviour
    do_reset();
    t60 = 0;
    for (int p = 0; p < 81; p++) begin
      if (p == 60) t60 = cyc;
      send_pixel(p);
    end
    wait_frames(1, 3000);
    check_writes(81);
    chk("wr60_latency", w60_cyc, t60 + 1);
    chk("first_start_latency", st1_cyc, t60 + 2);
    check_results(1);

    // Transmitter held off: the FIFO fills and scheduling stalls at 4 windows
    tx_hold = 1'b1;
    do_reset();
    for (int p = 0; p < 81; p++) send_pixel(p);
    repeat (40) @(negedge i_clk);
    chk("hold_starts", st_rows.size(), 4);
    chk("hold_tx_count", tx_bytes.size(), 0);
    chk("hold_busy", o_busy, 1'b1);
    tx_hold = 1'b0;
    wait_frames(1, 4000);
    check_results(1);

    // Pixel 70 enqueues in the same cycle the window from pixel 69 completes
    do_reset();
    for (int p = 0; p < 70; p++) send_pixel(p);
    repeat (3) @(negedge i_clk);
    for (int p = 70; p < 81; p++) send_pixel(p);
    wait_frames(1, 3000);
    check_results(1);

    // Reset mid-frame discards everything; a fresh frame then behaves normally
    do_reset();
    for (int p = 0; p < 66; p++) send_pixel(p);
    reset = 1'b1;
    @(negedge i_clk);
    chk_idle_outputs("midframe_reset");
    reset = 1'b0;
    n_st = st_rows.size();
    n_tx = tx_bytes.size();
    repeat (40) @(negedge i_clk);
    chk("post_reset_starts", st_rows.size(), n_st);
    chk("post_reset_tx", tx_bytes.size(), n_tx);
    chk("post_reset_busy", o_busy, 1'b0);
    do_reset();
    for (int p = 0; p < 81; p++) send_pixel(p);
    wait_frames(1, 3000);
    check_writes(81);
    check_results(1);

    // Two frames back to back: addresses and job anchors wrap
    do_reset();
    for (int p = 0; p < 162; p++) send_pixel(p);
    wait_frames(2, 6000);
    check_writes(162);
    check_results(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
